// File: rtl/tx_arb_pkg.sv
// tx_arb_pkg: shared state type and channel-ID width helper for the tx_streamer block arbiter.
package tx_arb_pkg;

    typedef enum logic [1:0] {IDLE, HEADER, STREAM, ABORT} t_arb_state;

    function automatic int f_log2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: combinational round-robin search, first requester at or above ptr with wrap.
module rr_priority_pick
    import tx_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = f_log2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          found
);

    // Walk downward so the lowest offset from ptr is the final winner.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % N]) begin
                idx   = IW'((int'(ptr) + i) % N);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tx_streamer_block_arbiter.sv
// tx_streamer_block_arbiter: round-robin sharing of one tx_streamer between block sources,
// switching only on block boundaries, with optional channel-ID header and stall abort.
module tx_streamer_block_arbiter
    import tx_arb_pkg::*;
#(
    parameter int                        g_data_width    = 64,
    parameter int                        g_num_channels  = 4,
    parameter int                        g_insert_header = 1,
    parameter int                        g_block_timeout = 256,
    parameter logic [g_data_width-1:0]   g_abort_word    = '1
) (
    input  logic                                   clk_sys_i,
    input  logic                                   rst_i,
    input  logic [g_num_channels-1:0]              ch_req_i,
    input  logic [g_num_channels*g_data_width-1:0] ch_data_i,
    input  logic [g_num_channels-1:0]              ch_valid_i,
    input  logic [g_num_channels-1:0]              ch_last_i,
    output logic [g_num_channels-1:0]              ch_dreq_o,
    output logic [g_data_width-1:0]                tx_data_o,
    output logic                                   tx_valid_o,
    output logic                                   tx_last_o,
    input  logic                                   tx_dreq_i,
    output logic [f_log2(g_num_channels)-1:0]      cur_chan_o,
    output logic                                   busy_o,
    output logic                                   timeout_p_o,
    output logic                                   err_p_o
);

    localparam int N  = g_num_channels;
    localparam int W  = g_data_width;
    localparam int IW = f_log2(N);
    localparam int TW = $clog2(g_block_timeout);
    localparam logic [N-1:0] ONE = 1;

    t_arb_state    state;
    logic [IW-1:0] ptr, pick, nxt;
    logic          found, g_valid, g_last;
    logic [TW-1:0] tcnt;
    logic [W-1:0]  g_data;
    logic [N-1:0]  grant_mask;

    rr_priority_pick #(.N(N), .IW(IW)) u_pick (
        .req   (ch_req_i),
        .ptr   (ptr),
        .idx   (pick),
        .found (found)
    );

    assign g_data     = ch_data_i[cur_chan_o*W +: W];
    assign g_valid    = ch_valid_i[cur_chan_o];
    assign g_last     = ch_last_i[cur_chan_o];
    assign grant_mask = (state == STREAM) ? ONE << cur_chan_o : '0;
    assign ch_dreq_o  = tx_dreq_i ? grant_mask : '0;
    assign nxt        = (cur_chan_o == IW'(N - 1)) ? '0 : cur_chan_o + 1'b1;
    assign busy_o     = state != IDLE;

    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            state       <= IDLE;
            ptr         <= '0;
            cur_chan_o  <= '0;
            tcnt        <= '0;
            tx_data_o   <= '0;
            tx_valid_o  <= 1'b0;
            tx_last_o   <= 1'b0;
            timeout_p_o <= 1'b0;
            err_p_o     <= 1'b0;
        end else begin
            tx_valid_o  <= 1'b0;
            tx_last_o   <= 1'b0;
            timeout_p_o <= 1'b0;
            err_p_o     <= |(ch_valid_i & ~grant_mask);
            case (state)
                IDLE: if (found) begin
                    cur_chan_o <= pick;
                    tcnt       <= '0;
                    state      <= (g_insert_header != 0) ? HEADER : STREAM;
                end
                HEADER: if (tx_dreq_i) begin
                    tx_data_o  <= W'(cur_chan_o);
                    tx_valid_o <= 1'b1;
                    tcnt       <= '0;
                    state      <= STREAM;
                end
                // Granted words are taken regardless of tx_dreq_i; tx_streamer has slack for them.
                STREAM: if (g_valid) begin
                    tx_data_o  <= g_data;
                    tx_valid_o <= 1'b1;
                    tx_last_o  <= g_last;
                    tcnt       <= '0;
                    if (g_last) begin
                        ptr   <= nxt;
                        state <= IDLE;
                    end
                end else if (tcnt == TW'(g_block_timeout - 1)) begin
                    state <= ABORT;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
                ABORT: if (tx_dreq_i) begin
                    tx_data_o   <= g_abort_word;
                    tx_valid_o  <= 1'b1;
                    tx_last_o   <= 1'b1;
                    timeout_p_o <= 1'b1;
                    ptr         <= nxt;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
